// File: rtl/leitor_teclado_pkg.sv
// ============================================================================
// leitor_teclado_pkg: shared types, key codes and helpers for the keypad reader
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package leitor_teclado_pkg;

  typedef enum logic [1:0] {
    VARRE    = 2'd0,
    CONFIRMA = 2'd1,
    EMITE    = 2'd2,
    SOLTA    = 2'd3
  } estado_t;

  localparam logic [3:0] TECLA_ASTERISCO = 4'hA;
  localparam logic [3:0] TECLA_CERQUILHA = 4'hB;

  // Rows 0..2 form the 1..9 block; row 3 holds *, 0, #.
  function automatic logic [3:0] mapeia_tecla(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] codigo;
    codigo = 4'h0;
    if (row == 2'd3) begin
      case (col)
        2'd0:    codigo = TECLA_ASTERISCO;
        2'd1:    codigo = 4'h0;
        default: codigo = TECLA_CERQUILHA;
      endcase
    end else begin
      codigo = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return codigo;
  endfunction

  function automatic logic [1:0] proxima_coluna(input logic [1:0] col);
    return (col >= 2'd2) ? 2'd0 : col + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/leitor_teclado_sincronizador.sv
// ============================================================================
// sincronizador: two-flop synchroniser, async active-low reset to all-ones
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sincronizador #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sinc_q, sinc_d;

  always_comb begin
    meta_d = d;
    sinc_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '1;
      sinc_q <= '1;
    end else begin
      meta_q <= meta_d;
      sinc_q <= sinc_d;
    end
  end

  assign q = sinc_q;

endmodule

`default_nettype wire

// File: rtl/leitor_teclado.sv
// ============================================================================
// leitor_teclado: 4x3 matrix keypad scanner, debouncer and key encoder
// Optional auto-repeat: define LEITOR_TECLADO_REPETE_EN.   Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module leitor_teclado
  import leitor_teclado_pkg::*;
#(
  parameter int SCAN_CYCLES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] linhas,
  output logic [2:0] colunas,
  output logic [3:0] numero,
  output logic       insere
);

  localparam int SW = $clog2(SCAN_CYCLES) + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [SW-1:0] SCAN_ULT = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ULT  = DW'(DEBOUNCE_CYCLES - 1);

  if (SCAN_CYCLES < 2) begin : g_scan_invalido
    $error("SCAN_CYCLES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_deb_invalido
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES < 2) begin : g_rep_invalido
    $error("REPEAT_CYCLES must be at least 2");
  end

  logic [3:0] ls;

  sincronizador #(.WIDTH(4)) u_sinc (
    .clk   (clk),
    .reset (reset),
    .d     (linhas),
    .q     (ls)
  );

  estado_t       estado_q, estado_d;
  logic [1:0]    col_q, col_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [1:0]    linha_q, linha_d;
  logic [3:0]    padrao_q, padrao_d;
  logic [3:0]    numero_q, numero_d;
  logic          insere_q, insere_d;

`ifdef LEITOR_TECLADO_REPETE_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RW-1:0] REP_ULT = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  logic       um_baixo;
  logic [1:0] linha_det;

  always_comb begin
    um_baixo  = 1'b1;
    linha_det = 2'd0;
    case (ls)
      4'b1110: linha_det = 2'd0;
      4'b1101: linha_det = 2'd1;
      4'b1011: linha_det = 2'd2;
      4'b0111: linha_det = 2'd3;
      default: um_baixo  = 1'b0;
    endcase
  end

  always_comb begin
    estado_d = estado_q;
    col_d    = col_q;
    scan_d   = scan_q;
    deb_d    = deb_q;
    linha_d  = linha_q;
    padrao_d = padrao_q;
    numero_d = numero_q;
    insere_d = 1'b0;
`ifdef LEITOR_TECLADO_REPETE_EN
    rep_d    = rep_q;
`endif

    case (estado_q)
      VARRE: begin
        if (scan_q >= SCAN_ULT) begin
          scan_d = '0;
          if (um_baixo) begin
            linha_d  = linha_det;
            padrao_d = ls;
            deb_d    = '0;
            estado_d = CONFIRMA;
          end else begin
            col_d = proxima_coluna(col_q);
          end
        end else begin
          scan_d = scan_q + SW'(1);
        end
      end

      CONFIRMA: begin
        if (ls == padrao_q) begin
          if (deb_q >= DEB_ULT) begin
            deb_d    = '0;
            estado_d = EMITE;
            numero_d = mapeia_tecla(linha_q, col_q);
            insere_d = 1'b1;
          end else begin
            deb_d = deb_q + DW'(1);
          end
        end else begin
          deb_d    = '0;
          scan_d   = '0;
          col_d    = proxima_coluna(col_q);
          estado_d = VARRE;
        end
      end

      EMITE: begin
        deb_d    = '0;
        estado_d = SOLTA;
`ifdef LEITOR_TECLADO_REPETE_EN
        // The strobe cycle already counts as one held cycle, so the period is exact.
        rep_d    = RW'(1);
`endif
      end

      SOLTA: begin
        if (ls == 4'hF) begin
          if (deb_q >= DEB_ULT) begin
            deb_d    = '0;
            scan_d   = '0;
            col_d    = 2'd0;
            estado_d = VARRE;
          end else begin
            deb_d = deb_q + DW'(1);
          end
        end else begin
          deb_d = '0;
        end
`ifdef LEITOR_TECLADO_REPETE_EN
        if (ls == padrao_q) begin
          if (rep_q >= REP_ULT) begin
            rep_d    = '0;
            estado_d = EMITE;
            insere_d = 1'b1;
          end else begin
            rep_d = rep_q + RW'(1);
          end
        end else begin
          rep_d = '0;
        end
`endif
      end

      default: estado_d = VARRE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q <= VARRE;
      col_q    <= 2'd0;
      scan_q   <= '0;
      deb_q    <= '0;
      linha_q  <= 2'd0;
      padrao_q <= 4'hF;
      numero_q <= 4'h0;
      insere_q <= 1'b0;
`ifdef LEITOR_TECLADO_REPETE_EN
      rep_q    <= '0;
`endif
    end else begin
      estado_q <= estado_d;
      col_q    <= col_d;
      scan_q   <= scan_d;
      deb_q    <= deb_d;
      linha_q  <= linha_d;
      padrao_q <= padrao_d;
      numero_q <= numero_d;
      insere_q <= insere_d;
`ifdef LEITOR_TECLADO_REPETE_EN
      rep_q    <= rep_d;
`endif
    end
  end

  // Columns follow the next-state column so the row lines have settled through
  // the synchroniser by the time the last cycle of each slot samples them.
  assign colunas = ~(3'b001 << col_d);
  assign numero  = numero_q;
  assign insere  = insere_q;

endmodule

`default_nettype wire

// File: tb/tb_leitor_teclado.sv
// ============================================================================
// tb_leitor_teclado: directed, scoreboard-based bench for leitor_teclado
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_leitor_teclado;
  import leitor_teclado_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] linhas;
  logic [2:0] colunas;
  logic [3:0] numero;
  logic       insere;

  // Per-column mask of rows currently pressed (1 = pressed).
  logic [3:0] mask0 = 4'h0;
  logic [3:0] mask1 = 4'h0;
  logic [3:0] mask2 = 4'h0;

  int tests = 0;
  int fails = 0;
  int strobes = 0;
  int cyc = 0;
  int last_strobe_cyc = -1;
  int strobe_gap = 0;
  logic insere_ant = 1'b0;
  logic [3:0] fila[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign linhas = ~((colunas[0] ? 4'h0 : mask0) |
                    (colunas[1] ? 4'h0 : mask1) |
                    (colunas[2] ? 4'h0 : mask2));

  leitor_teclado #(
    .SCAN_CYCLES     (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .linhas  (linhas),
    .colunas (colunas),
    .numero  (numero),
    .insere  (insere)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] prox(input logic [2:0] c);
    case (c)
      3'b110:  return 3'b101;
      3'b101:  return 3'b011;
      3'b011:  return 3'b110;
      default: return 3'bxxx;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (insere) begin
        check("insere_width", {31'd0, insere_ant}, 0);
        strobes++;
        if (last_strobe_cyc >= 0) begin
          strobe_gap = cyc - last_strobe_cyc;
          check("strobe_gap_min", {31'd0, strobe_gap >= 10}, 1);
        end
        last_strobe_cyc = cyc;
        check("strobe_expected", {31'd0, fila.size() != 0}, 1);
        if (fila.size() != 0) check("numero", {28'd0, numero}, {28'd0, fila.pop_front()});
      end
      insere_ant = insere;
    end else begin
      insere_ant = 1'b0;
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic espera_strobes(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (strobes < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(tag, {31'd0, strobes >= n}, 1);
  endtask

  task automatic solta_tudo();
    mask0 = 4'h0;
    mask1 = 4'h0;
    mask2 = 4'h0;
  endtask

  task automatic aperta(input int r, input int c);
    logic [3:0] m;
    m = 4'h1 << r;
    case (c)
      0:       mask0 = m;
      1:       mask1 = m;
      default: mask2 = m;
    endcase
  endtask

  task automatic tecla(input int r, input int c, input logic [3:0] code, input string tag);
    int n;
    n = strobes + 1;
    fila.push_back(code);
    aperta(r, c);
    espera_strobes(n, 60, tag);
    ciclos(5);
    solta_tudo();
    ciclos(20);
  endtask

  initial begin
    logic [2:0] s[12];
    int n;
    int k;

    // Reset state
    ciclos(3);
    check("reset_colunas", {29'd0, colunas}, 3'b110);
    check("reset_numero", {28'd0, numero}, 4'h0);
    check("reset_insere", {31'd0, insere}, 0);

    // Column rotation after reset release
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s[i] = colunas;
      @(negedge clk);
    end
    check("rot_first", {29'd0, s[0]}, 3'b110);
    for (int i = 0; i < 10; i++) check("rot_step", {29'd0, s[i+2]}, {29'd0, prox(s[i])});

    // Clean press of 5, held long: exactly one strobe
    n = strobes + 1;
    fila.push_back(4'h5);
    mask1 = 4'b0010;
    espera_strobes(n, 60, "press5_timeout");
`ifndef LEITOR_TECLADO_REPETE_EN
    ciclos(100);
    check("hold_no_repeat", strobes, n);
`endif
    solta_tudo();
    ciclos(20);

    // Bounce on row 2 / column 1, then stable press of 8
    n = strobes;
    for (int i = 0; i < 30; i++) begin
      mask1 = mask1 ^ 4'b0100;
      @(negedge clk);
    end
    check("bounce_no_strobe", strobes, n);
    tecla(2, 1, 4'h8, "bounce8_timeout");

    // Sequence 5, 8, 9, 2, 0, 4
    tecla(1, 1, 4'h5, "seq5_timeout");
    tecla(2, 1, 4'h8, "seq8_timeout");
    tecla(2, 2, 4'h9, "seq9_timeout");
    tecla(0, 1, 4'h2, "seq2_timeout");
    tecla(3, 1, 4'h0, "seq0_timeout");
    tecla(1, 0, 4'h4, "seq4_timeout");

    // Star, hash, then ghost (two rows on one column)
    tecla(3, 0, TECLA_ASTERISCO, "star_timeout");
    tecla(3, 2, TECLA_CERQUILHA, "hash_timeout");
    n = strobes;
    mask0 = 4'b0011;
    ciclos(40);
    check("ghost_no_strobe", strobes, n);
    solta_tudo();
    ciclos(10);

    // Reset pulsed while confirming key 1
    n = strobes;
    mask0 = 4'b0001;
    k = 0;
    while (dut.estado_q != CONFIRMA && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("reach_confirma", {31'd0, k < 60}, 1);
    reset = 1'b0;
    #1;
    check("midreset_colunas", {29'd0, colunas}, 3'b110);
    check("midreset_numero", {28'd0, numero}, 4'h0);
    check("midreset_insere", {31'd0, insere}, 0);
    check("midreset_no_strobe", strobes, n);
    ciclos(3);
    fila.push_back(4'h1);
    reset = 1'b1;
    espera_strobes(n + 1, 60, "after_reset1_timeout");
    ciclos(3);
    solta_tudo();
    ciclos(20);

`ifdef LEITOR_TECLADO_REPETE_EN
    // Auto-repeat of 3 every 16 cycles
    n = strobes;
    fila.push_back(4'h3);
    fila.push_back(4'h3);
    fila.push_back(4'h3);
    mask2 = 4'b0001;
    espera_strobes(n + 1, 60, "rep_first_timeout");
    espera_strobes(n + 2, 40, "rep_second_timeout");
    check("rep_period_1", strobe_gap, 16);
    espera_strobes(n + 3, 40, "rep_third_timeout");
    check("rep_period_2", strobe_gap, 16);
    solta_tudo();
    ciclos(20);
`endif

    check("queue_drained", fila.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
